// File: rtl/shift_add_mul16.sv
// 16x16 unsigned shift-and-add multiplier that uses a 16-bit carry-lookahead adder.
// Latency: 17 cycles from the accepting start edge to the one-cycle done pulse.
// Backpressure: start is only sampled in IDLE or DONE; it is ignored while busy.

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        C,
    output logic        G,
    output logic        P
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [4:0]  bc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        pg = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
    end

    // Second lookahead level across the four nibble groups.
    always_comb begin
        bc    = '0;
        bc[0] = cin;
        bc[1] = gg[0] | (pg[0] & cin);
        bc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        bc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);
        bc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
    end

    assign s = p ^ c;
    assign C = bc[4];
    assign G = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
             | (pg[3] & pg[2] & pg[1] & gg[0]);
    assign P = &pg;
endmodule

module shift_add_mul16 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [4:0]  cnt;
    logic [15:0] sum;
    logic        carry;
    logic [1:0]  unused_gp;
    logic        accept;

    cla16 u_cla (
        .a   (hi),
        .b   (lo[0] ? mcand : 16'h0000),
        .cin (1'b0),
        .s   (sum),
        .C   (carry),
        .G   (unused_gp[1]),
        .P   (unused_gp[0])
    );

    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 5'd15) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // The adder carry-out becomes hi[15] so the 17-bit partial sum is never truncated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
        end else if (state == RUN) begin
            {hi, lo} <= {carry, sum, lo[15:1]};
            cnt      <= cnt + 5'd1;
        end
    end

    assign p = {hi, lo};
endmodule

// File: tb/tb_shift_add_mul16.sv
// Directed bench for shift_add_mul16: latency, product values, ignored starts,
// back-to-back operation and asynchronous reset abort.
module tb_shift_add_mul16;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    shift_add_mul16 dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] x, input logic [15:0] y);
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called just after the accepting edge; returns in the done cycle, or one cycle later if !hold.
    task automatic wait_done(input string tag, input logic [31:0] exp_p,
                             input bit disturb, input bit hold);
        int cyc = 0;
        int nb = 0;
        int d0 = done_seen;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nb++;
            if (disturb && (cyc == 3 || cyc == 10)) begin
                start = 1'b1;
                a = 16'($urandom);
                b = 16'($urandom);
            end else if (!hold) begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd16);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd16);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_p"}, p, exp_p);
        if (!hold) begin
            step();
            chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
            chk({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
            chk({tag, "_p_held"}, p, exp_p);
        end
    endtask

    initial begin
        int d0;
        rstn  = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_p", p, 32'd0);
        rstn = 1'b1;
        step();
        step();
        chk("idle_p", p, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Basic product and timing
        accept(16'h0003, 16'h0005);
        wait_done("mul_3x5", 32'h0000_000F, 1'b0, 1'b0);

        // Carry-out into hi on every step
        accept(16'hFFFF, 16'hFFFF);
        wait_done("mul_max", 32'hFFFE_0001, 1'b0, 1'b0);

        // Zero operands
        accept(16'h1234, 16'h0000);
        wait_done("mul_b0", 32'h0000_0000, 1'b0, 1'b0);
        accept(16'h0000, 16'hABCD);
        wait_done("mul_a0", 32'h0000_0000, 1'b0, 1'b0);

        // Start pulses and operand changes during RUN are ignored
        accept(16'h00FF, 16'h0100);
        wait_done("mul_ignore", 32'h0000_FF00, 1'b1, 1'b0);
        repeat (20) step();
        chk("ignore_no_extra_done", {31'd0, done}, 32'd0);
        chk("ignore_idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back with start held high
        a = 16'h8000;
        b = 16'h0002;
        start = 1'b1;
        step();
        a = 16'h00FF;
        b = 16'h00FF;
        wait_done("b2b_first", 32'h0001_0000, 1'b0, 1'b1);
        step();
        start = 1'b0;
        wait_done("b2b_second", 32'h0000_FE01, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        accept(16'h1111, 16'h2222);
        repeat (8) step();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_p", p, 32'd0);
        step();
        rstn = 1'b1;
        d0 = done_seen;
        repeat (20) step();
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        chk("abort_idle_p", p, 32'd0);
        accept(16'h1111, 16'h2222);
        wait_done("mul_after_abort", 32'h0246_8642, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_add_mul16.md
Name: shift_add_mul16

Overview:
- Sequential 16x16 unsigned multiplier that consumes the 16-bit carry-lookahead adder (cla16) as its only adder.
- One partial-product add-and-shift per clock. The full 32-bit product is ready 16 cycles after start.
- Sits downstream of cla16 in the datapath. It is the first multi-cycle arithmetic block built on it and becomes the multiply unit for the lab ALU.

Parameters:
- None. Width is fixed at 16 by the instantiated cla16.

Ports:
- clk    input   1   system clock; all state updates on its rising edge
- rstn   input   1   asynchronous active-low reset
- start  input   1   request to begin a multiply; sampled only when idle or done
- a      input   16  multiplicand, unsigned; captured on the accepted start
- b      input   16  multiplier, unsigned; captured on the accepted start
- busy   output  1   high while a multiply is in progress
- done   output  1   one-cycle pulse when the product becomes valid
- p      output  32  product {hi, lo}; held stable until the next accepted start

Behaviour:
- Reset is asynchronous on rstn low and forces:
  - state = IDLE;
  - busy = 0, done = 0, p = 0;
  - internal multiplicand register, cycle counter and carry flag = 0.
- Reset mid-operation aborts the multiply with no completion pulse. After rstn rises, the block waits for a new start.
- Registers:
  - mcand[15:0] holds the multiplicand.
  - hi[15:0] and lo[15:0] form the product/multiplier shift register; p = {hi, lo}.
  - cnt[4:0] counts the add-and-shift steps.
- Adder hookup: cla16 is instantiated once with a = hi, b = (lo[0] ? mcand : 16'h0000), cin = 0. Its sum s[15:0] and carry-out C form a 17-bit result. The G and P outputs are unused.
- State machine:
  - IDLE:
    - start = 1: mcand <= a, hi <= 0, lo <= b, cnt <= 0, go to RUN. busy rises in the next cycle.
    - start = 0: hold. p keeps its last value.
  - RUN, each cycle:
    - {hi, lo} <= {C, s, lo[15:1]}, i.e. a logical right shift of the 17-bit sum concatenated with lo.
    - cnt <= cnt + 1.
    - When cnt == 15 (the 16th step), go to DONE.
    - start is ignored in RUN. Inputs a and b may change freely without effect.
  - DONE (exactly one cycle):
    - done = 1, busy = 0, and p holds the final product.
    - With start = 1, the new operands are accepted exactly as in IDLE and the next state is RUN. This gives back-to-back operation with no idle gap.
    - Otherwise go to IDLE.
- busy = 1 exactly in the RUN state, for 16 cycles.
- Latency: start sampled high at edge N puts done high during the cycle after edge N+16 (17 cycles from the accepting edge to the done cycle).
- Arithmetic rules:
  - The product is exact for all operand pairs, with no overflow.
  - Maximum result: 0xFFFF * 0xFFFF = 0xFFFE0001.
  - The carry-out C must be shifted into hi[15]. Dropping it is a defect.
- p is a direct view of {hi, lo}, so it changes every cycle during RUN. Consumers sample p only on done or while busy = 0.
- start held high continuously produces back-to-back multiplies. Each pair is captured from the a and b values present at the accepting cycle (IDLE or DONE).
- No X propagation: all registers must have defined reset values.

Test Plan:
1. Reset, then a=0x0003, b=0x0005, one-cycle start. Required response: busy high for 16 cycles, done pulses exactly once in the 17th cycle after the accepting edge, p=0x0000000F.
2. a=0xFFFF, b=0xFFFF. Required response: p=0xFFFE0001 on done. This checks carry-out propagation into hi on every step.
3. a=0x1234, b=0x0000, then a=0x0000, b=0xABCD. Required response: p=0x00000000 both times, with done timing identical to scenario 1.
4. Start accepted with a=0x00FF, b=0x0100. Pulse start again and change a/b at cycles 3 and 10 of RUN. Required response: both pulses ignored, p=0x0000FF00, one done only.
5. start held high with operand pairs (0x8000,0x0002) then (0x00FF,0x00FF). Required response: done pulses 17 cycles apart with no idle cycle between runs, p=0x00010000 then 0x0000FE01.
6. Drop rstn low for one cycle at RUN cycle 8 of a=0x1111, b=0x2222. Required response:
   - busy, done and p go to 0 immediately, asynchronously, without waiting for a clock edge;
   - no done pulse follows;
   - a fresh start with the same operands yields p=0x02468642.
